// File: rtl/reg_file_mm.sv
// reg_file_mm: parametrised CPU register file with two registered read ports,
// one write port, full write-through bypass, hardwired zero, link capture,
// keyboard capture and memory-mapped special registers.
module reg_file_mm #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              stall,
    input  logic              link_we,
    input  logic [DATA_W-1:0] link_pc,
    input  logic [DATA_W-1:0] key_in,
    output logic              key_pending,
    input  logic [DATA_W-1:0] smem_rdata,
    output logic [DATA_W-1:0] smem_addr,
    output logic [DATA_W-1:0] smem_wdata,
    output logic [DATA_W-1:0] gmem_addr,
    output logic [DATA_W-1:0] gmem_wdata,
    output logic [DATA_W-1:0] syscode,
    output logic [DATA_W-1:0] comp
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int R_ZERO  = 0;
    localparam int R_SR    = 7;
    localparam int R_SA    = 8;
    localparam int R_SW    = 9;
    localparam int R_GA    = 10;
    localparam int R_GW    = 11;
    localparam int R_SYS   = 12;
    localparam int R_C     = 13;
    localparam int R_MPC   = 14;
    localparam int R_KEY   = 15;

    logic [DATA_W-1:0] regs     [DEPTH];
    logic [DATA_W-1:0] regs_nxt [DEPTH];
    logic              key_hit;
    logic              key_read;

    assign key_hit  = (key_in != '0);
    assign key_read = !stall &&
                      ((raddr_a == ADDR_W'(R_KEY)) || (raddr_b == ADDR_W'(R_KEY)));

    // Per-register next state; read ports sample this so writes bypass same-edge.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_nxt[i] = regs[i];
            if (i == R_ZERO) begin
                regs_nxt[i] = '0;
            end else if (i == R_SR) begin
                regs_nxt[i] = smem_rdata;
            end else if (i == R_MPC) begin
                if (link_we)
                    regs_nxt[i] = link_pc;
                else if (we && waddr == ADDR_W'(i))
                    regs_nxt[i] = wdata;
            end else if (i == R_KEY) begin
                if (key_hit)
                    regs_nxt[i] = key_in;
                else if (we && waddr == ADDR_W'(i))
                    regs_nxt[i] = wdata;
            end else if (we && waddr == ADDR_W'(i)) begin
                regs_nxt[i] = wdata;
            end
        end
    end

    // Storage flops; reset clears everything, including the sr load.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst)
                regs[i] <= '0;
            else
                regs[i] <= regs_nxt[i];
        end
    end

    // Registered read ports, frozen while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else if (!stall) begin
            rdata_a <= regs_nxt[raddr_a];
            rdata_b <= regs_nxt[raddr_b];
        end
    end

    // Key pending: a new key wins over a clearing read in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)
            key_pending <= 1'b0;
        else if (key_hit)
            key_pending <= 1'b1;
        else if (key_read)
            key_pending <= 1'b0;
    end

    // Mapped outputs come straight from storage, never from the bypass path.
    assign smem_addr  = regs[R_SA];
    assign smem_wdata = regs[R_SW];
    assign gmem_addr  = regs[R_GA];
    assign gmem_wdata = regs[R_GW];
    assign syscode    = regs[R_SYS];
    assign comp       = regs[R_C];

endmodule

// File: tb/tb_reg_file_mm.sv
// Directed self-checking bench for reg_file_mm.
module tb_reg_file_mm;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        stall;
    logic        link_we;
    logic [31:0] link_pc;
    logic [31:0] key_in;
    logic        key_pending;
    logic [31:0] smem_rdata;
    logic [31:0] smem_addr;
    logic [31:0] smem_wdata;
    logic [31:0] gmem_addr;
    logic [31:0] gmem_wdata;
    logic [31:0] syscode;
    logic [31:0] comp;

    int checks = 0;
    int failures = 0;

    reg_file_mm #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .stall(stall), .link_we(link_we), .link_pc(link_pc), .key_in(key_in),
        .key_pending(key_pending), .smem_rdata(smem_rdata), .smem_addr(smem_addr),
        .smem_wdata(smem_wdata), .gmem_addr(gmem_addr), .gmem_wdata(gmem_wdata),
        .syscode(syscode), .comp(comp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hAA;
        raddr_a = 5'd0; raddr_b = 5'd0; stall = 1'b0;
        link_we = 1'b0; link_pc = 32'h0; key_in = 32'd5; smem_rdata = 32'h77;

        // Reset with competing writes, key and smem activity
        step(); step();
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_rdata_b", rdata_b, 32'h0);
        check("rst_smem_addr", smem_addr, 32'h0);
        check("rst_smem_wdata", smem_wdata, 32'h0);
        check("rst_gmem_addr", gmem_addr, 32'h0);
        check("rst_gmem_wdata", gmem_wdata, 32'h0);
        check("rst_syscode", syscode, 32'h0);
        check("rst_comp", comp, 32'h0);
        check("rst_key_pending", {31'b0, key_pending}, 32'h0);

        // First cycle out of reset: sr loads, reg 3 was not written
        rst = 1'b0; we = 1'b0; key_in = 32'h0; raddr_a = 5'd7; raddr_b = 5'd3;
        step();
        check("sr_after_rst", rdata_a, 32'h77);
        check("reg3_after_rst", rdata_b, 32'h0);
        check("pend_after_rst", {31'b0, key_pending}, 32'h0);

        // Write with same-edge bypass
        we = 1'b1; waddr = 5'd3; wdata = 32'h1234; raddr_a = 5'd3;
        step();
        check("bypass_reg3", rdata_a, 32'h1234);

        // Zero register ignores writes
        waddr = 5'd0; wdata = 32'hFFFF; raddr_a = 5'd0;
        step();
        check("zero_bypass", rdata_a, 32'h0);
        we = 1'b0;
        step();
        check("zero_read", rdata_a, 32'h0);

        // Mapped outputs
        we = 1'b1; waddr = 5'd8; wdata = 32'h100;
        step();
        check("smem_addr", smem_addr, 32'h100);
        waddr = 5'd11; wdata = 32'hCAFE;
        step();
        check("gmem_wdata", gmem_wdata, 32'hCAFE);
        waddr = 5'd13; wdata = 32'h1;
        step();
        check("comp", comp, 32'h1);
        waddr = 5'd9; wdata = 32'h9;
        step();
        check("smem_wdata", smem_wdata, 32'h9);
        waddr = 5'd10; wdata = 32'hA0;
        step();
        check("gmem_addr", gmem_addr, 32'hA0);
        waddr = 5'd12; wdata = 32'h55;
        #1;
        check("sys_no_bypass", syscode, 32'h0);
        step();
        check("syscode", syscode, 32'h55);
        check("smem_addr_kept", smem_addr, 32'h100);

        // sr ignores general writes
        waddr = 5'd7; wdata = 32'hDEAD; smem_rdata = 32'h88; raddr_a = 5'd7;
        step();
        check("sr_we_ignored", rdata_a, 32'h88);

        // Link beats general write to mpc
        link_we = 1'b1; link_pc = 32'h40; waddr = 5'd14; wdata = 32'h99; raddr_b = 5'd14;
        step();
        check("link_bypass", rdata_b, 32'h40);
        link_we = 1'b0; we = 1'b0;
        step();
        check("link_stored", rdata_b, 32'h40);

        // Keyboard capture and pending flag
        raddr_a = 5'd0; raddr_b = 5'd0; key_in = 32'h41;
        step();
        check("key_set", {31'b0, key_pending}, 32'h1);
        key_in = 32'h0;
        step();
        check("key_hold", {31'b0, key_pending}, 32'h1);
        stall = 1'b1; raddr_a = 5'd15;
        step();
        check("key_stall_read", {31'b0, key_pending}, 32'h1);
        stall = 1'b0;
        step();
        check("key_clear", {31'b0, key_pending}, 32'h0);
        check("key_value", rdata_a, 32'h41);
        raddr_a = 5'd0; raddr_b = 5'd15; key_in = 32'h42;
        step();
        check("key_read_new", {31'b0, key_pending}, 32'h1);
        check("key_bypass", rdata_b, 32'h42);
        key_in = 32'h0; raddr_b = 5'd0;
        step();
        check("key_still_set", {31'b0, key_pending}, 32'h1);

        // Stall holds read data while writes proceed
        raddr_a = 5'd3; raddr_b = 5'd14;
        step();
        check("pre_stall", rdata_a, 32'h1234);
        stall = 1'b1; raddr_a = 5'd4; raddr_b = 5'd0; we = 1'b1; waddr = 5'd3; wdata = 32'h5;
        step();
        check("stall_hold_a", rdata_a, 32'h1234);
        check("stall_hold_b", rdata_b, 32'h40);
        we = 1'b0;
        step();
        check("stall_hold_a2", rdata_a, 32'h1234);
        stall = 1'b0; raddr_a = 5'd3;
        step();
        check("post_stall", rdata_a, 32'h5);

        // Reset mid-run
        rst = 1'b1; key_in = 32'h7;
        step();
        check("rst2_pending", {31'b0, key_pending}, 32'h0);
        check("rst2_comp", comp, 32'h0);
        check("rst2_rdata_a", rdata_a, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
